// File: rtl/mpc_dot_pkg.sv
// Shared types and default widths for the dot-product accumulator slice.
// Latency: n/a (declarations only).
// Backpressure: n/a. Used by mpc_dot_accum, mpc_dot_accum_if and mpc_round_sat.
package mpc_dot_pkg;

    localparam int DEF_ACC_W  = 44;   // signed accumulator width
    localparam int DEF_PROD_W = 36;   // signed product term width
    localparam int DEF_OUT_W  = 21;   // signed result width
    localparam int DEF_SHIFT  = 13;   // fractional bits dropped on output
    localparam int CNT_W      = 8;    // term counter, wraps modulo 256

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no term of the current vector accepted yet
        ST_ACC  = 2'd1,   // partial sum held
        ST_HOLD = 2'd2    // result presented, waiting for consumer
    } state_e;

endpackage

// File: rtl/mpc_dot_accum_if.sv
// Term-in / result-out bundle of the dot-product accumulator.
// Latency: n/a. Ports: prod/prod_valid/prod_last/in_ready (term side),
// Backpressure: in_ready low while a result waits; out_valid/out_ready handshake.
interface mpc_dot_accum_if
    import mpc_dot_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int OUT_W  = DEF_OUT_W
);
    logic signed [PROD_W-1:0] prod;
    logic                     prod_valid;
    logic                     prod_last;
    logic                     in_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic [CNT_W-1:0]         out_count;
    logic                     out_ovf;
    logic                     out_valid;
    logic                     out_ready;

    // master: multiplier upstream plus result consumer
    modport master (
        output prod, prod_valid, prod_last, out_ready,
        input  in_ready, out_data, out_count, out_ovf, out_valid
    );

    // slave: the accumulator itself
    modport slave (
        input  prod, prod_valid, prod_last, out_ready,
        output in_ready, out_data, out_count, out_ovf, out_valid
    );
endinterface

// File: rtl/mpc_round_sat.sv
// Round-half-up by SHIFT bits, then saturate (MPC_DOT_ACCUM_SAT_EN) or wrap to OUT_W.
// Latency: combinational. Ports: acc_i (signed sum) -> data_o, ovf_o.
// Backpressure: none. Without MPC_DOT_ACCUM_SAT_EN, ovf_o is tied 0.
module mpc_round_sat #(
    parameter int ACC_W = 44,
    parameter int OUT_W = 21,
    parameter int SHIFT = 13
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [OUT_W-1:0] data_o,
    output logic                    ovf_o
);
    // One guard bit so adding the half-LSB can never wrap a near-max sum.
    localparam int EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) << (SHIFT - 1);

    logic signed [EXT_W-1:0] rounded;

    assign rounded = $signed({acc_i[ACC_W-1], acc_i}) + HALF;

`ifdef MPC_DOT_ACCUM_SAT_EN
    localparam logic signed [EXT_W-1:0] MAX_V = (EXT_W'(1) << (OUT_W - 1)) - EXT_W'(1);
    localparam logic signed [EXT_W-1:0] MIN_V = -MAX_V - EXT_W'(1);

    logic signed [EXT_W-1:0] shifted;

    always_comb begin
        shifted = rounded >>> SHIFT;
        data_o  = OUT_W'(shifted);
        ovf_o   = 1'b0;
        if (shifted > MAX_V) begin
            data_o = OUT_W'(MAX_V);
            ovf_o  = 1'b1;
        end else if (shifted < MIN_V) begin
            data_o = OUT_W'(MIN_V);
            ovf_o  = 1'b1;
        end
    end
`else
    assign data_o = OUT_W'(rounded >>> SHIFT);
    assign ovf_o  = 1'b0;
`endif

endmodule

// File: rtl/mpc_dot_accum.sv
// Dot-product accumulator: sums signed terms until prod_last, then presents a rounded result.
// Latency: result registered on the last beat, out_valid one cycle later. Ports: clk, rst, clear, bus.
// Backpressure: in_ready drops while a result waits for out_ready. Optional saturation via MPC_DOT_ACCUM_SAT_EN.
module mpc_dot_accum
    import mpc_dot_pkg::*;
#(
    parameter int ACC_W  = DEF_ACC_W,
    parameter int PROD_W = DEF_PROD_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int SHIFT  = DEF_SHIFT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    mpc_dot_accum_if.slave    bus
);
    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [OUT_W-1:0] out_data_q;
    logic [CNT_W-1:0]        out_count_q;
    logic                    out_ovf_q;
    logic                    load_out;
    logic                    beat;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [OUT_W-1:0] rs_data;
    logic                    rs_ovf;

    assign prod_ext = {{(ACC_W - PROD_W){bus.prod[PROD_W-1]}}, bus.prod};
    assign beat     = bus.prod_valid && bus.in_ready;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        load_out = 1'b0;
        if (clear) begin
            // Abort wins over any beat or result handshake this cycle.
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (beat) begin
                    acc_d    = prod_ext;
                    cnt_d    = CNT_W'(1);
                    state_d  = bus.prod_last ? ST_HOLD : ST_ACC;
                    load_out = bus.prod_last;
                end
                ST_ACC: if (beat) begin
                    acc_d    = acc_q + prod_ext;
                    cnt_d    = cnt_q + CNT_W'(1);
                    state_d  = bus.prod_last ? ST_HOLD : ST_ACC;
                    load_out = bus.prod_last;
                end
                ST_HOLD: if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Rounds the sum being formed this cycle so the result lands with the last beat.
    mpc_round_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .acc_i  (acc_d),
        .data_o (rs_data),
        .ovf_o  (rs_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            if (load_out) begin
                out_data_q  <= rs_data;
                out_count_q <= cnt_d;
                out_ovf_q   <= rs_ovf;
            end
        end
    end

    assign bus.in_ready  = (state_q != ST_HOLD);
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mpc_dot_accum.sv
// Directed bench for mpc_dot_accum: rounding, count wrap, backpressure, abort, saturation/wrap.
// Latency: checks result one cycle after the last beat.
// Backpressure: holds out_ready low to stall the block.
module tb_mpc_dot_accum;
    import mpc_dot_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    int   checks = 0;
    int   errors = 0;

`ifdef MPC_DOT_ACCUM_SAT_EN
    localparam logic signed [63:0] EXP_POS = 64'sd1048575;
    localparam logic signed [63:0] EXP_NEG = -64'sd1048576;
    localparam logic signed [63:0] EXP_OVF = 64'sd1;
`else
    localparam logic signed [63:0] EXP_POS = 64'sd0;
    localparam logic signed [63:0] EXP_NEG = 64'sd0;
    localparam logic signed [63:0] EXP_OVF = 64'sd0;
`endif

    always #5 clk = ~clk;

    mpc_dot_accum_if #(.PROD_W(DEF_PROD_W), .OUT_W(DEF_OUT_W)) bus ();

    mpc_dot_accum dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one term and returns after the edge that accepted it.
    task automatic send(input logic signed [63:0] v, input logic last);
        int n = 0;
        bus.prod       = DEF_PROD_W'(v);
        bus.prod_valid = 1'b1;
        bus.prod_last  = last;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: in_ready observed 0 expected 1");
        end
        tick();
        bus.prod_valid = 1'b0;
        bus.prod_last  = 1'b0;
    endtask

    // Waits for a result, checks it, then completes the handshake.
    task automatic recv(input string tag, input logic signed [63:0] exp_data,
                        input logic signed [63:0] exp_cnt, input logic signed [63:0] exp_ovf);
        int n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 64'(bus.out_valid), 64'sd1);
        check({tag, "_data"},  $signed(bus.out_data), exp_data);
        check({tag, "_count"}, 64'(bus.out_count), exp_cnt);
        check({tag, "_ovf"},   64'(bus.out_ovf), exp_ovf);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_drop"}, 64'(bus.out_valid), 64'sd0);
    endtask

    initial begin
        rst            = 1'b1;
        clear          = 1'b0;
        bus.prod       = '0;
        bus.prod_valid = 1'b0;
        bus.prod_last  = 1'b0;
        bus.out_ready  = 1'b0;
        tick();
        tick();
        check("rst_in_ready",  64'(bus.in_ready), 64'sd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'sd0);
        check("rst_out_data",  $signed(bus.out_data), 64'sd0);
        check("rst_out_count", 64'(bus.out_count), 64'sd0);
        check("rst_out_ovf",   64'(bus.out_ovf), 64'sd0);
        rst = 1'b0;
        tick();

        // Single beat: 8192 >> 13 = 1, valid exactly one cycle after the beat.
        bus.prod = DEF_PROD_W'(8192); bus.prod_valid = 1'b1; bus.prod_last = 1'b1;
        check("lat_pre_valid", 64'(bus.out_valid), 64'sd0);
        tick();
        bus.prod_valid = 1'b0; bus.prod_last = 1'b0;
        check("lat_post_valid", 64'(bus.out_valid), 64'sd1);
        recv("single", 64'sd1, 64'sd1, 64'sd0);

        // 4096 + 4096 - 4096 = 4096 = half LSB, rounds up to 1.
        send(64'sd4096, 1'b0);
        send(64'sd4096, 1'b0);
        send(-64'sd4096, 1'b1);
        recv("half_up", 64'sd1, 64'sd3, 64'sd0);

        // Rounding edges: -4096 -> 0, -4097 -> -1, 12287 -> 1, 12288 -> 2.
        send(-64'sd4096, 1'b1);
        recv("neg_half", 64'sd0, 64'sd1, 64'sd0);
        send(-64'sd4097, 1'b1);
        recv("neg_below", -64'sd1, 64'sd1, 64'sd0);
        send(64'sd12287, 1'b1);
        recv("below_1p5", 64'sd1, 64'sd1, 64'sd0);
        send(64'sd12288, 1'b1);
        recv("at_1p5", 64'sd2, 64'sd1, 64'sd0);

        // +2^40 built from 64 x 2^34; shifted value 2^27 clips or wraps to 0.
        for (int i = 0; i < 64; i++) send(64'sh4_0000_0000, i == 63);
        recv("big_pos", EXP_POS, 64'sd64, EXP_OVF);
        // -2^40 built from 32 x -2^35.
        for (int i = 0; i < 32; i++) send(-64'sh8_0000_0000, i == 31);
        recv("big_neg", EXP_NEG, 64'sd32, EXP_OVF);

        // prod_last without prod_valid is ignored.
        send(64'sd8192, 1'b0);
        bus.prod_last = 1'b1;
        tick();
        tick();
        bus.prod_last = 1'b0;
        check("last_no_valid", 64'(bus.out_valid), 64'sd0);
        send(64'sd8192, 1'b1);
        recv("last_ignored", 64'sd2, 64'sd2, 64'sd0);

        // Backpressure: next term waits through 5 stalled cycles and the handshake cycle.
        send(64'sd8192, 1'b1);
        bus.prod = DEF_PROD_W'(16384); bus.prod_valid = 1'b1; bus.prod_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", 64'(bus.in_ready), 64'sd0);
            check("bp_data",     $signed(bus.out_data), 64'sd1);
            check("bp_valid",    64'(bus.out_valid), 64'sd1);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_hs_valid",    64'(bus.out_valid), 64'sd0);
        check("bp_hs_in_ready", 64'(bus.in_ready), 64'sd1);
        tick();
        bus.prod_valid = 1'b0; bus.prod_last = 1'b0;
        recv("bp_next", 64'sd2, 64'sd1, 64'sd0);

        // Reset mid-vector discards the partial sum.
        send(64'sd100000, 1'b0);
        send(64'sd200000, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_mid_in_ready", 64'(bus.in_ready), 64'sd1);
        tick();
        rst = 1'b0;
        tick();
        send(64'sd8192, 1'b1);
        recv("after_rst", 64'sd1, 64'sd1, 64'sd0);

        // Clear mid-vector discards the partial sum.
        send(64'sd100000, 1'b0);
        send(64'sd200000, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        send(64'sd8192, 1'b1);
        recv("after_clear", 64'sd1, 64'sd1, 64'sd0);

        // Clear overrides a simultaneous final beat.
        bus.prod = DEF_PROD_W'(8192); bus.prod_valid = 1'b1; bus.prod_last = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0; bus.prod_valid = 1'b0; bus.prod_last = 1'b0;
        check("clr_beat_valid", 64'(bus.out_valid), 64'sd0);
        tick();
        check("clr_beat_valid2", 64'(bus.out_valid), 64'sd0);

        // Clear while a result is held drops out_valid.
        send(64'sd8192, 1'b1);
        check("clr_hold_pre", 64'(bus.out_valid), 64'sd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_hold_valid",    64'(bus.out_valid), 64'sd0);
        check("clr_hold_in_ready", 64'(bus.in_ready), 64'sd1);

        // 256 zero terms: count wraps to 0.
        for (int i = 0; i < 256; i++) send(64'sd0, i == 255);
        recv("wrap256", 64'sd0, 64'sd0, 64'sd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
